ucsbece154b_dmem_resp: RTL and testbench

//  Data-memory responder for the M-stage load/store port of the pipelined RISC-V core.

---
 rtl/ucsbece154b_dmem_resp_pkg.sv | 39 +++
 rtl/ucsbece154b_dmem_resp_array.sv | 24 ++
 rtl/ucsbece154b_dmem_resp.sv | 162 ++++++++++++++++
 tb/tb_ucsbece154b_dmem_resp.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ucsbece154b_dmem_resp_pkg.sv
// Shared definitions for the M-stage data-memory responder: FSM encoding,
// funct3 access-size codes and the sub-word load extension helper.
package ucsbece154b_dmem_resp_pkg;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_DONE = 2'd2
  } dmem_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Pick the addressed byte/half out of a word and sign- or zero-extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] w,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  boff);
    logic [7:0]  b;
    logic [15:0] h;
    case (boff)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = boff[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_B:    load_extend = {{24{b[7]}}, b};
      F3_BU:   load_extend = {24'd0, b};
      F3_H:    load_extend = {{16{h[15]}}, h};
      F3_HU:   load_extend = {16'd0, h};
      default: load_extend = w;
    endcase
  endfunction

endpackage

// File: rtl/ucsbece154b_dmem_resp_array.sv
// Word-organised data storage: byte-enable synchronous write, combinational read.
// Contents are deliberately left unreset.
module ucsbece154b_dmem_array
  #(parameter int DEPTH_WORDS = 64)
  (
    input  logic                           clk,
    input  logic [3:0]                     we_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] waddr_i,
    input  logic [31:0]                    wdata_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] raddr_i,
    output logic [31:0]                    rdata_o
  );

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ucsbece154b_dmem_resp.sv
// M-stage data-memory responder: fixed-latency loads with a stall request,
// single-cycle stores, access-fault flag. Sub-word access with DMEM_BYTE_WRITE_EN.
module ucsbece154b_dmem_resp
  import ucsbece154b_dmem_resp_pkg::*;
  #(parameter int          DEPTH_WORDS  = 64,
    parameter int          READ_LATENCY = 2,
    parameter logic [31:0] ADDR_BASE    = 32'h0000_0000)
  (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM_i,
    input  logic        MemWriteM_i,
    input  logic [31:0] AddrM_i,
    input  logic [31:0] WriteDataM_i,
    input  logic [2:0]  funct3M_i,
    output logic [31:0] ReadDataM_o,
    output logic        BusyM_o,
    output logic        ErrM_o
  );

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  dmem_state_e      state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [29:0]      idx_full;
  logic [IDX_W-1:0] idx, raddr;
  logic             idle, req, bad, range_err, align_err, size_err;
  logic             load_ok, store_ok;
  logic [3:0]       be;
  logic [31:0]      wdata, arr_rdata, load_data;

  // Addresses below ADDR_BASE wrap to a huge index and are caught as range errors.
  assign idx_full  = 30'((AddrM_i - ADDR_BASE) >> 2);
  assign idx       = idx_full[IDX_W-1:0];
  assign range_err = idx_full >= 30'(DEPTH_WORDS);
  assign idle      = (state_q == DMEM_IDLE);
  assign req       = MemReadM_i | MemWriteM_i;

`ifdef DMEM_BYTE_WRITE_EN
  logic [2:0] f3_q;
  logic [1:0] boff_q;

  always_comb begin
    align_err = 1'b0;
    size_err  = 1'b0;
    be        = 4'b0000;
    wdata     = WriteDataM_i;
    if (MemWriteM_i && !MemReadM_i) begin
      case (funct3M_i)
        F3_B: begin
          be    = 4'b0001 << AddrM_i[1:0];
          wdata = {4{WriteDataM_i[7:0]}};
        end
        F3_H: begin
          align_err = AddrM_i[0];
          be        = AddrM_i[1] ? 4'b1100 : 4'b0011;
          wdata     = {2{WriteDataM_i[15:0]}};
        end
        F3_W: begin
          align_err = |AddrM_i[1:0];
          be        = 4'b1111;
        end
        default: size_err = 1'b1;
      endcase
    end else begin
      case (funct3M_i)
        F3_B, F3_BU: align_err = 1'b0;
        F3_H, F3_HU: align_err = AddrM_i[0];
        F3_W:        align_err = |AddrM_i[1:0];
        default:     size_err  = 1'b1;
      endcase
    end
  end

  // A single-cycle load extends from the live request; longer ones use what was latched.
  assign load_data = idle ? load_extend(arr_rdata, funct3M_i, AddrM_i[1:0])
                          : load_extend(arr_rdata, f3_q, boff_q);

  always_ff @(posedge clk) begin
    if (load_ok) begin
      f3_q   <= funct3M_i;
      boff_q <= AddrM_i[1:0];
    end
  end
`else
  logic unused_f3;
  assign unused_f3 = ^funct3M_i;
  assign align_err = |AddrM_i[1:0];
  assign size_err  = 1'b0;
  assign be        = 4'b1111;
  assign wdata     = WriteDataM_i;
  assign load_data = arr_rdata;
`endif

  assign bad      = range_err | align_err | size_err | (MemReadM_i & MemWriteM_i);
  assign ErrM_o   = ~reset & idle & req & bad;
  assign load_ok  = ~reset & idle & MemReadM_i & ~bad;
  assign store_ok = ~reset & idle & MemWriteM_i & ~bad;
  assign BusyM_o  = load_ok | (~reset & (state_q == DMEM_WAIT));
  assign raddr    = idle ? idx : idx_q;

  ucsbece154b_dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk     (clk),
    .we_i    (store_ok ? be : 4'b0000),
    .waddr_i (idx),
    .wdata_i (wdata),
    .raddr_i (raddr),
    .rdata_o (arr_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    case (state_q)
      DMEM_IDLE: begin
        if (load_ok) begin
          idx_d = idx;
          cnt_d = 3'(READ_LATENCY - 1);
          if (READ_LATENCY == 1) begin
            rdata_d = load_data;
            state_d = DMEM_DONE;
          end else begin
            state_d = DMEM_WAIT;
          end
        end
      end
      DMEM_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rdata_d = load_data;
          state_d = DMEM_DONE;
        end
      end
      DMEM_DONE: state_d = DMEM_IDLE;
      default:   state_d = DMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= 3'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    idx_q <= idx_d;
  end

  assign ReadDataM_o = rdata_q;

endmodule

// File: tb/tb_ucsbece154b_dmem_resp.sv
// Scoreboard bench for ucsbece154b_dmem_resp (L=2 main instance, L=1/L=7 sweep instances).
module tb_ucsbece154b_dmem_resp;

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;

  logic        clk, reset;
  logic        rd, wr;
  logic [31:0] addr, wdat;
  logic [2:0]  f3;
  logic [31:0] rdata;
  logic        busy, err;

  logic        rd_s [2];
  logic        wr_s [2];
  logic [31:0] rdata_s [2];
  logic        busy_s [2];
  logic        err_s [2];

  exp_t        sb_q[$];
  int          n_checks, n_fail;
  logic [31:0] last_rd;

  ucsbece154b_dmem_resp #(.DEPTH_WORDS(64), .READ_LATENCY(2)) dut (
    .clk(clk), .reset(reset), .MemReadM_i(rd), .MemWriteM_i(wr), .AddrM_i(addr),
    .WriteDataM_i(wdat), .funct3M_i(f3), .ReadDataM_o(rdata), .BusyM_o(busy), .ErrM_o(err));

  ucsbece154b_dmem_resp #(.DEPTH_WORDS(64), .READ_LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset), .MemReadM_i(rd_s[0]), .MemWriteM_i(wr_s[0]), .AddrM_i(addr),
    .WriteDataM_i(wdat), .funct3M_i(f3), .ReadDataM_o(rdata_s[0]), .BusyM_o(busy_s[0]),
    .ErrM_o(err_s[0]));

  ucsbece154b_dmem_resp #(.DEPTH_WORDS(64), .READ_LATENCY(7)) dut_l7 (
    .clk(clk), .reset(reset), .MemReadM_i(rd_s[1]), .MemWriteM_i(wr_s[1]), .AddrM_i(addr),
    .WriteDataM_i(wdat), .funct3M_i(f3), .ReadDataM_o(rdata_s[1]), .BusyM_o(busy_s[1]),
    .ErrM_o(err_s[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // All driver tasks start and end just after a rising edge.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] fc);
    wr = 1'b1; addr = a; wdat = d; f3 = fc;
    @(negedge clk);
    chk("store_err", {31'd0, err}, 32'd0);
    chk("store_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] exp, input logic [2:0] fc);
    bit done;
    done = 1'b0;
    sb_q.push_back('{data: exp, lat: 2});
    rd = 1'b1; addr = a; f3 = fc;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!busy) begin done = 1'b1; break; end
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL load_timeout: busy still 1 after 20 cycles, expected 0");
    end
    last_rd = exp;
    @(posedge clk); #1;
    rd = 1'b0;
  endtask

  task automatic do_bad(input string name, input logic r, input logic w, input logic [31:0] a);
    rd = r; wr = w; addr = a; wdat = 32'h1234_5678; f3 = 3'b010;
    @(negedge clk);
    chk({name, "_err"}, {31'd0, err}, 32'd1);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk({name, "_rdata"}, rdata, last_rd);
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic sweep(input int k, input int lat);
    int  width;
    bit  done;
    width = 0; done = 1'b0;
    wr_s[k] = 1'b1; addr = 32'h10; wdat = 32'hDEAD_BEEF; f3 = 3'b010;
    @(posedge clk); #1;
    wr_s[k] = 1'b0; rd_s[k] = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (busy_s[k]) width++;
      else begin done = 1'b1; break; end
    end
    chk($sformatf("sweep_L%0d_done", lat), {31'd0, done}, 32'd1);
    chk($sformatf("sweep_L%0d_width", lat), width, lat);
    chk($sformatf("sweep_L%0d_data", lat), rdata_s[k], 32'hDEAD_BEEF);
    @(posedge clk); #1;
    rd_s[k] = 1'b0;
  endtask

  // Monitor: a falling BusyM_o marks the DONE cycle of the main instance.
  initial begin : monitor
    int   run;
    logic prev;
    exp_t e;
    run = 0; prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        run = 0; prev = 1'b0;
      end else begin
        if (busy) run++;
        else if (prev) begin
          if (sb_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL sb_unexpected: got data 0x%08h, expected no response", rdata);
          end else begin
            e = sb_q.pop_front();
            chk("load_data", rdata, e.data);
            chk("busy_width", run, e.lat);
          end
          run = 0;
        end
        prev = busy;
      end
    end
  end

  initial begin
    n_checks = 0; n_fail = 0; last_rd = 32'd0;
    reset = 1'b1; rd = 1'b1; wr = 1'b0; addr = 32'h12; wdat = 32'd0; f3 = 3'b010;
    rd_s[0] = 1'b0; rd_s[1] = 1'b0; wr_s[0] = 1'b0; wr_s[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    rd = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    do_store(32'h10, 32'hDEAD_BEEF, 3'b010);
    do_store(32'h14, 32'h0000_CAFE, 3'b010);
    do_load(32'h10, 32'hDEAD_BEEF, 3'b010);
    do_load(32'h10, 32'hDEAD_BEEF, 3'b010);
    do_load(32'h14, 32'h0000_CAFE, 3'b010);

    do_bad("misalign", 1'b1, 1'b0, 32'h12);
    do_bad("range", 1'b1, 1'b0, 32'h100);
    do_bad("rd_and_wr", 1'b1, 1'b1, 32'h10);
    do_bad("st_range", 1'b0, 1'b1, 32'h100);
    do_load(32'h10, 32'hDEAD_BEEF, 3'b010);

    // Abort a load in WAIT with an asynchronous reset.
    rd = 1'b1; addr = 32'h10;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    rd = 1'b0; last_rd = 32'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    do_load(32'h14, 32'h0000_CAFE, 3'b010);

`ifdef DMEM_BYTE_WRITE_EN
    do_store(32'h20, 32'h1122_3344, 3'b010);
    do_store(32'h21, 32'h0000_0080, 3'b000);
    do_load(32'h20, 32'h1122_8044, 3'b010);
    do_load(32'h21, 32'hFFFF_FF80, 3'b000);
    do_load(32'h21, 32'h0000_0080, 3'b100);
`endif

    sweep(0, 1);
    sweep(1, 7);

    repeat (2) @(posedge clk);
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
